// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//   Round-robin arbiter that shares one 4:1 single-bit mux among four
//   requesters. The grant drives the mux select lines; the selected bit is
//   registered together with the index of the requester it came from.
//
//   Handshake: req[i] is a level request. Requester i owns the mux from the
//   cycle after grant[i] is seen high until it drops req[i] or is pre-empted
//   after MAX_HOLD consecutive cycles while someone else waits. valid marks a
//   cycle whose out/out_id carry a sample taken during a grant cycle; there is
//   no backpressure from the consumer.
//
// Parameters
//   MAX_HOLD    : max consecutive grant cycles under contention (1..255)
// Ports
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset
//   req[3:0]    : request bit per requester
//   in0..in3    : data bit per requester (mux data inputs)
//   grant[3:0]  : registered one-hot owner, 0000 when idle
//   addr0/addr1 : registered mux select, {addr1,addr0} = owner index
//   out         : registered mux output
//   out_id[1:0] : index of the requester whose bit is on out
//   valid       : out/out_id hold a real sample
//   dbg_state_o : arbiter FSM state (0 = IDLE, 1 = GRANT)
//   dbg_hold_o  : current hold counter, zero-extended
// -----------------------------------------------------------------------------

// Plain 4:1 single-bit multiplexer.
module mux4 (
    input  logic       in0_i,
    input  logic       in1_i,
    input  logic       in2_i,
    input  logic       in3_i,
    input  logic [1:0] sel_i,
    output logic       out_o
);
    always_comb begin
        case (sel_i)
            2'd0:    out_o = in0_i;
            2'd1:    out_o = in1_i;
            2'd2:    out_o = in2_i;
            default: out_o = in3_i;
        endcase
    end
endmodule

module mux_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [3:0] grant,
    output logic       addr0,
    output logic       addr1,
    output logic       out,
    output logic [1:0] out_id,
    output logic       valid,
    output logic       dbg_state_o,
    output logic [7:0] dbg_hold_o
);
    localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    last_q,  last_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    addr_q,  addr_d;
    logic          out_q;
    logic [1:0]    out_id_q;
    logic          valid_q;

    logic [3:0]    cand;
    logic          pick_found;
    logic [1:0]    pick_idx;
    logic [1:0]    idx;
    logic          mux_out;

    mux4 u_mux (
        .in0_i (in0),
        .in1_i (in1),
        .in2_i (in2),
        .in3_i (in3),
        .sel_i (addr_q),
        .out_o (mux_out)
    );

    // Round-robin pick over cand, starting just after last_q. Scanning the
    // offsets from farthest to nearest lets the nearest hit overwrite.
    always_comb begin
        cand = (state_q == S_IDLE) ? req : (req & ~(4'b0001 << owner_q));
        pick_found = 1'b0;
        pick_idx   = last_q;
        idx        = 2'd0;
        for (int off = 4; off >= 1; off--) begin
            idx = last_q + 2'(off);
            if (cand[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_GRANT;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                    addr_d  = pick_idx;
                    hold_d  = HW'(1);
                end
            end
            default: begin
                if (!req[owner_q] || (hold_q == HOLD_MAX)) begin
                    // Release or quota exhausted: hand over if anyone else waits.
                    if (pick_found) begin
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                        grant_d = 4'b0001 << pick_idx;
                        addr_d  = pick_idx;
                        hold_d  = HW'(1);
                    end else if (!req[owner_q]) begin
                        state_d = S_IDLE;
                        grant_d = 4'b0000;
                    end
                    // else: sole holder at the limit keeps the grant, hold saturated
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 2'd0;
            last_q   <= 2'd3;
            hold_q   <= '0;
            grant_q  <= 4'b0000;
            addr_q   <= 2'd0;
            out_q    <= 1'b0;
            out_id_q <= 2'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            // Output stage samples the mux with the select that was live
            // during this cycle.
            out_q    <= mux_out;
            out_id_q <= addr_q;
            valid_q  <= (grant_q != 4'b0000);
        end
    end

    assign grant       = grant_q;
    assign addr0       = addr_q[0];
    assign addr1       = addr_q[1];
    assign out         = out_q;
    assign out_id      = out_id_q;
    assign valid       = valid_q;
    assign dbg_state_o = state_q;
    assign dbg_hold_o  = 8'(hold_q);
endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       in0, in1, in2, in3;

    logic [3:0] grant,  grant1;
    logic       addr0,  addr1,  addr0_1, addr1_1;
    logic       out,    out1;
    logic [1:0] out_id, out_id1;
    logic       valid,  valid1;
    logic       st,     st1;
    logic [7:0] hold,   hold1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req(req),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .grant(grant), .addr0(addr0), .addr1(addr1),
        .out(out), .out_id(out_id), .valid(valid),
        .dbg_state_o(st), .dbg_hold_o(hold)
    );

    mux_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .req(req),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .grant(grant1), .addr0(addr0_1), .addr1(addr1_1),
        .out(out1), .out_id(out_id1), .valid(valid1),
        .dbg_state_o(st1), .dbg_hold_o(hold1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] prev_idx;
        logic [1:0] cur_idx;
        reset = 1'b1;
        req   = 4'b0000;
        {in3, in2, in1, in0} = 4'b0000;
        step();
        step();

        // Reset with all requests asserted
        reset = 1'b1;
        req   = 4'b1111;
        step();
        chk("rst_grant", {4'b0, grant}, 8'h00);
        chk("rst_addr",  {6'b0, addr1, addr0}, 8'h00);
        chk("rst_valid", {7'b0, valid}, 8'h00);
        chk("rst_state", {7'b0, st}, 8'h00);
        reset = 1'b0;
        step();
        chk("rst_first_grant", {4'b0, grant}, 8'h01);
        step();
        chk("rst_first_valid", {7'b0, valid}, 8'h01);

        // Single requester 2
        do_reset();
        req = 4'b0100;
        in2 = 1'b1;
        step();
        chk("single_grant", {4'b0, grant}, 8'h04);
        chk("single_addr",  {6'b0, addr1, addr0}, 8'h02);
        chk("single_valid0", {7'b0, valid}, 8'h00);
        step();
        chk("single_out",    {7'b0, out}, 8'h01);
        chk("single_out_id", {6'b0, out_id}, 8'h02);
        chk("single_valid1", {7'b0, valid}, 8'h01);
        req = 4'b0000;
        step();
        chk("single_rel_grant", {4'b0, grant}, 8'h00);
        chk("single_rel_valid", {7'b0, valid}, 8'h01);
        step();
        chk("single_idle_valid", {7'b0, valid}, 8'h00);
        chk("single_idle_addr",  {6'b0, addr1, addr0}, 8'h02);
        in2 = 1'b0;

        // Full contention: MAX_HOLD=4 holds 4 cycles, MAX_HOLD=1 rotates each cycle
        do_reset();
        {in3, in2, in1, in0} = 4'b0101;
        req = 4'b1111;
        prev_idx = 2'd0;
        for (int c = 0; c < 20; c++) begin
            step();
            cur_idx = 2'((c / 4) % 4);
            chk($sformatf("cont_grant_%0d", c), {4'b0, grant}, 8'h01 << cur_idx);
            chk($sformatf("cont_addr_%0d", c), {6'b0, addr1, addr0}, {6'b0, cur_idx});
            chk($sformatf("rot1_grant_%0d", c), {4'b0, grant1}, 8'h01 << (c % 4));
            if (c >= 1) begin
                chk($sformatf("cont_out_id_%0d", c), {6'b0, out_id}, {6'b0, prev_idx});
                chk($sformatf("cont_out_%0d", c), {7'b0, out}, {7'b0, ~prev_idx[0]});
                chk($sformatf("cont_valid_%0d", c), {7'b0, valid}, 8'h01);
            end
            prev_idx = cur_idx;
        end
        {in3, in2, in1, in0} = 4'b0000;

        // Release handoff 1 -> 3 without idle bubble
        do_reset();
        req = 4'b0010;
        step();
        chk("hand_grant1", {4'b0, grant}, 8'h02);
        req = 4'b1010;
        step();
        chk("hand_grant1b", {4'b0, grant}, 8'h02);
        req = 4'b1000;
        step();
        chk("hand_grant3", {4'b0, grant}, 8'h08);
        step();
        chk("hand_valid",  {7'b0, valid}, 8'h01);
        chk("hand_out_id", {6'b0, out_id}, 8'h03);
        chk("hand_grant3b", {4'b0, grant}, 8'h08);

        // Sole holder saturates, then yields to a new request
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("sole_grant_%0d", c), {4'b0, grant}, 8'h02);
        end
        chk("sole_hold", hold, 8'h04);
        req = 4'b0011;
        step();
        chk("sole_preempt", {4'b0, grant}, 8'h01);
        chk("sole_preempt_hold", hold, 8'h01);

        // Mid-grant reset
        do_reset();
        req = 4'b1111;
        step();
        step();
        chk("mid_pre_grant", {4'b0, grant}, 8'h01);
        reset = 1'b1;
        step();
        chk("mid_grant",  {4'b0, grant}, 8'h00);
        chk("mid_addr",   {6'b0, addr1, addr0}, 8'h00);
        chk("mid_out",    {7'b0, out}, 8'h00);
        chk("mid_out_id", {6'b0, out_id}, 8'h00);
        chk("mid_valid",  {7'b0, valid}, 8'h00);
        chk("mid_hold",   hold, 8'h00);
        reset = 1'b0;
        step();
        chk("mid_restart", {4'b0, grant}, 8'h01);
        chk("mid_valid_after", {7'b0, valid}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter and sequencer for the team's 4:1 single-bit multiplexer, sharing one mux path among four requesters. It decides which requester owns the mux each cycle and drives the mux select lines `addr0`/`addr1` from the current grant. It instantiates the 4:1 multiplexer internally and registers the selected bit together with the owner's index. The block sits between four independent single-bit sources and one shared downstream consumer.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one requester may hold the grant while another requester is waiting. Legal range is 1..255.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; takes effect at the next rising edge of `clk`.
- `req` in 4: request bit per requester; `req[i]` pairs with `in<i>`.
- `in0`..`in3` in 1 each: data bit per requester; these are the mux data inputs.
- `grant` out 4: registered one-hot owner; `0000` when idle.
- `addr0`, `addr1` out 1 each: registered mux select; `{addr1,addr0}` equals the index of the granted requester.
- `out` out 1: registered mux output, sampled in a grant cycle.
- `out_id` out 2: registered index of the requester whose bit is on `out`.
- `valid` out 1: `out` and `out_id` hold a real sample.

## Operation
- Internal state:
  - `state` is IDLE or GRANT.
  - `owner[1:0]` is the current grant holder.
  - `last[1:0]` is the most recent grant holder.
  - `hold` is a counter of `$clog2(MAX_HOLD)+1` bits.
- Reset values:
  - `grant=0000`, `addr1=0`, `addr0=0`, `out=0`, `out_id=00`, `valid=0`.
  - `state=IDLE`, `last=3` (so requester 0 wins first), `hold=0`.
- RR pick: from `req` masked to exclude `except`, choose the first set bit in the order `last+1`, `last+2`, `last+3`, `last` (mod 4).
- IDLE:
  - If `req≠0`: pick winner k, set `owner=last=k`, `grant=1<<k`, `{addr1,addr0}=k`, `hold=1`, go to GRANT.
  - Otherwise remain in IDLE; `addr` keeps its previous value so the select does not glitch.
- GRANT with owner k, evaluated on each edge:
  - `req[k]=0` (release):
    - If other requests are pending, grant the RR winner directly; no idle bubble; `hold=1`.
    - Otherwise clear `grant` and go to IDLE.
  - `req[k]=1` and `hold<MAX_HOLD`: keep the grant and increment `hold`.
  - `req[k]=1`, `hold==MAX_HOLD`, and another `req[j]` with j≠k is pending: pre-empt. Grant the RR winner among j≠k and set `hold=1`.
  - `req[k]=1`, `hold==MAX_HOLD`, and no other request: keep the grant; `hold` saturates at `MAX_HOLD`.
- Output register on every edge:
  - `valid ← (grant≠0)`.
  - `out ← mux(in0..in3, addr)`.
  - `out_id ← {addr1,addr0}`.
  - While `grant=0`, `out` and `out_id` still update, but `valid=0`.
- `grant` is always one-hot or zero. `{addr1,addr0}` always matches the set `grant` bit while `grant≠0`.

## Timing
- `req` rises at edge N-1 (sampled at N) → `grant`/`addr` valid after edge N → `out`/`valid` valid after edge N+1. Request-to-grant latency is 1 cycle; grant-to-data latency is 1 cycle.
- Release: `req[k]` sampled low at edge N → new owner or `grant=0000` after edge N.
- Under full contention with all `req=1111`, each owner holds for exactly `MAX_HOLD` cycles, and the rotation is 0,1,2,3,0…
- With `MAX_HOLD=1` under contention, the grant rotates every cycle.
- A requester that drops and re-raises `req` in the same cycle the grant moves away from it does not keep priority; it waits for its RR turn.
- Reset asserted mid-GRANT: at the next edge, all state and outputs take their reset values regardless of `req`. No partial transfer is flagged, so `valid=0` on the cycle after reset.
- `req` changing between edges has no effect until the next edge. There is no combinational path from `req` or `in*` to any output.

## Test plan
- Reset with `req=1111` held → `grant=0000`, `addr=00`, `valid=0` after the reset edge. One edge after deassertion, `grant=0001`.
- Single requester: `req=0100`, `in2=1` → the next edge gives `grant=0100`, `{addr1,addr0}=10`. The edge after that gives `out=1`, `out_id=10`, `valid=1`. Dropping `req` → `grant=0000`, and `valid=0` one edge later.
- Contention, `MAX_HOLD=4`, `req=1111` for 20 cycles → grant sequence is 0001×4, 0010×4, 0100×4, 1000×4, 0001×4.
- Release handoff: owner 1 drops `req` while `req[3]=1` → the next edge gives `grant=1000` with no idle cycle between.
- Sole holder: `req=0010` for 10 cycles → `grant=0010` throughout, with `hold` saturated at 4. Raising `req[0]` at that point → the next edge gives `grant=0001`.
- Mid-grant reset with `req=1111` after 2 cycles of ownership → all outputs at reset values. Arbitration restarts at requester 0.
